// File: rtl/l2_l1_responder.sv
// l2_l1_responder: L2-side responder for L1 refill (read) and write-back
// (write) requests against a 2^INDEX_W x 512-bit line array.
//
// Ports:
//   clk               single clock, rising edge
//   nrst              asynchronous active-low reset
//   read_req_L1_L2    refill request, held until ready_L2_L1
//   write_req_L1_L2   write-back request, held until ready_L2_L1
//   addr_L1_L2        block address, index = addr[6+INDEX_W-1:6]
//   write_data_L1_L2  write-back block
//   read_data_L2_L1   registered refill block
//   ready_L2_L1       one-cycle completion pulse
//   busy_L2           high whenever the FSM is not idle
//
// Flow: IDLE accepts (write wins) -> WAIT counts LATENCY-1..0 -> RESP
// (ready pulse, array access happens on entry) -> DONE until both
// requests drop -> IDLE.
module l2_l1_responder #(
  parameter int INDEX_W = 8,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         read_req_L1_L2,
  input  logic         write_req_L1_L2,
  input  logic [31:0]  addr_L1_L2,
  input  logic [511:0] write_data_L1_L2,
  output logic [511:0] read_data_L2_L1,
  output logic         ready_L2_L1,
  output logic         busy_L2
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [INDEX_W-1:0]   idx_q, idx_d;
  logic                 is_wr_q, is_wr_d;
  logic [511:0]         wdata_q, wdata_d;
  logic [511:0]         rdata_q, rdata_d;
  // Per-line written flag. Clearing it asynchronously makes every line
  // read as zero after reset without having to reset the storage itself.
  logic [LINES-1:0]     lvld_q, lvld_d;
  logic                 mem_we;

  logic [511:0]         mem [LINES];

  logic unused_addr;
  assign unused_addr = ^{addr_L1_L2[5:0], addr_L1_L2[31:6+INDEX_W]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    is_wr_d = is_wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lvld_d  = lvld_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_req_L1_L2 || read_req_L1_L2) begin
          idx_d   = addr_L1_L2[6 +: INDEX_W];
          is_wr_d = write_req_L1_L2;
          if (write_req_L1_L2) wdata_d = write_data_L1_L2;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (is_wr_q) begin
            mem_we        = 1'b1;
            lvld_d[idx_q] = 1'b1;
          end else begin
            rdata_d = lvld_q[idx_q] ? mem[idx_q] : '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = DONE;
      DONE: begin
        if (!write_req_L1_L2 && !read_req_L1_L2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      is_wr_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      lvld_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      is_wr_q <= is_wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lvld_q  <= lvld_d;
    end
  end

  // mem_we can only assert out of WAIT, so a reset abort never writes.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign read_data_L2_L1 = rdata_q;
  assign ready_L2_L1     = (state_q == RESP);
  assign busy_L2         = (state_q != IDLE);

endmodule

// File: tb/tb_l2_l1_responder.sv
// Randomized bench for l2_l1_responder against a line-array reference model.
module tb_l2_l1_responder;
  localparam int INDEX_W = 8;
  localparam int LATENCY = 2;
  localparam int LINES   = 1 << INDEX_W;

  logic         clk = 0;
  logic         nrst = 0;
  logic         rd_req = 0, wr_req = 0;
  logic [31:0]  addr = '0;
  logic [511:0] wdata = '0;
  logic [511:0] rdata;
  logic         ready, busy;

  int total = 0, bad = 0;

  logic [511:0] ref_mem [LINES];
  logic [511:0] ref_rd;

  l2_l1_responder #(.INDEX_W(INDEX_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .nrst(nrst),
    .read_req_L1_L2(rd_req), .write_req_L1_L2(wr_req),
    .addr_L1_L2(addr), .write_data_L1_L2(wdata),
    .read_data_L2_L1(rdata), .ready_L2_L1(ready), .busy_L2(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ridx(input logic [31:0] a);
    return int'(a[6 +: INDEX_W]);
  endfunction

  function automatic logic [31:0] mk_addr(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[6 +: INDEX_W] = idx[INDEX_W-1:0];
    return a;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) ref_mem[i] = '0;
    ref_rd = '0;
  endtask

  // One full handshake. Inputs are driven away from posedge; the next
  // posedge is the acceptance edge. Ready is expected at negedge LATENCY+1.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [511:0] d, input int hold, input bit jitter);
    int k;
    bit seen;
    rd_req = rd; wr_req = wr; addr = a; wdata = d;
    @(posedge clk);
    if (wr) ref_mem[ridx(a)] = d;
    else    ref_rd = ref_mem[ridx(a)];
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      #1;
      if (jitter) begin addr = $urandom; wdata = {16{$urandom}}; end
      @(negedge clk);
      k++;
      if (ready) seen = 1;
      else chk("busy_wait", {511'd0, busy}, 512'd1);
    end
    chk("latency", 512'(k), 512'(LATENCY + 1));
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk("ready_once", {511'd0, ready}, 512'd0);
      chk("busy_hold", {511'd0, busy}, 512'd1);
    end
    rd_req = 0; wr_req = 0;
    @(negedge clk);
    chk("idle_after", {511'd0, busy}, 512'd0);
    chk("rdata", rdata, ref_rd);
  endtask

  initial begin
    logic [511:0] pat;
    logic [31:0]  a;
    int           idx;
    int           pulses;
    model_clear();

    // reset state
    #3;
    chk("rst_busy", {511'd0, busy}, 512'd0);
    chk("rst_ready", {511'd0, ready}, 512'd0);
    chk("rst_rdata", rdata, 512'd0);
    @(negedge clk); nrst = 1;

    // read of an untouched line returns zero
    txn(1, 0, mk_addr(5), '0, 0, 0);
    // write then read back, neighbour untouched
    pat = {16{32'hA5A5_0001}};
    txn(0, 1, mk_addr(5), pat, 0, 1);
    txn(1, 0, mk_addr(5), '0, 0, 0);
    chk("idx5_data", rdata, pat);
    txn(1, 0, mk_addr(4), '0, 0, 0);
    // simultaneous read+write: write first, then the read sees it
    txn(1, 1, mk_addr(9), '1, 0, 0);
    txn(1, 0, mk_addr(9), '0, 0, 0);
    chk("idx9_ones", rdata, '1);
    // request held long after ready
    txn(1, 0, mk_addr(5), '0, 10, 1);

    // reset abort in WAIT of a write to index 3
    rd_req = 0; wr_req = 1; addr = mk_addr(3); wdata = {16{32'hDEAD_BEEF}};
    @(posedge clk);
    @(negedge clk);
    nrst = 0;
    #1;
    chk("abort_busy", {511'd0, busy}, 512'd0);
    chk("abort_ready", {511'd0, ready}, 512'd0);
    chk("abort_rdata", rdata, 512'd0);
    wr_req = 0;
    model_clear();
    @(negedge clk); nrst = 1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (ready) pulses++; end
    chk("abort_nopulse", 512'(pulses), 512'd0);
    txn(1, 0, mk_addr(3), '0, 0, 0);
    txn(1, 0, mk_addr(5), '0, 0, 0);

    // top index with address bits above the index field set
    pat = {16{$urandom}};
    a = mk_addr(LINES - 1); a[31:6+INDEX_W] = '1;
    txn(0, 1, a, pat, 1, 0);
    a = mk_addr(LINES - 1);
    txn(1, 0, a, '0, 0, 0);
    chk("top_idx", rdata, pat);

    // random traffic over a small index pool so reads hit earlier writes
    for (int n = 0; n < 80; n++) begin
      bit r, w;
      case ($urandom_range(0, 2))
        0: begin r = 1; w = 0; end
        1: begin r = 0; w = 1; end
        default: begin r = 1; w = 1; end
      endcase
      idx = ($urandom_range(0, 3) == 0) ? (LINES - 1) : $urandom_range(0, 7);
      pat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      txn(r, w, mk_addr(idx), pat, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
